nibble_serial_add32: RTL and testbench
======================================

NIBBLE_SERIAL_ADD32 -- requirements
Module: nibble_serial_add32

Interface
REQ-001 The block SHALL have one parameter: NIBBLES, default 8, number of 4-bit slices; operand width = 4*NIBBLES (32 at default).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have a port start, input, 1 bit: request to add a, b, ci.
REQ-005 The block SHALL have a port a, input, 32 bits: operand A.
REQ-006 The block SHALL have a port b, input, 32 bits: operand B.
REQ-007 The block SHALL have a port ci, input, 1 bit: carry-in to bit 0.
REQ-008 The block SHALL have a port s, output, 32 bits: registered sum.
REQ-009 The block SHALL have a port co, output, 1 bit: registered carry-out of bit 31.
REQ-010 The block SHALL have a port ov, output, 1 bit: registered two's-complement signed overflow.
REQ-011 The block SHALL have a port busy, output, 1 bit: high while an operation is in progress.
REQ-012 The block SHALL have a port done, output, 1 bit: one-cycle pulse when s/co/ov are updated.

Function
REQ-013 The block SHALL compute {co,s} = a + b + ci using one cla4 instance, one nibble per cycle, LSB nibble first.
REQ-014 The block SHALL implement a two-state FSM: IDLE (busy=0) and BUSY (busy=1).
REQ-015 In IDLE with start=1 at edge E0, the block SHALL capture a, b, ci, a[31], b[31] into internal registers, clear the nibble counter, and enter BUSY.
REQ-016 At each BUSY edge Ek (k=1..8), the block SHALL feed the current low nibbles of the captured operands plus the carry register to cla4, store the 4-bit sum into result nibble k-1, load the carry register with the cla4 co, shift the operands right by 4, and increment the counter.
REQ-017 At E8, the block SHALL update s, co, ov, set done=1 for exactly the following cycle, and return to IDLE; latency from the start edge to the done cycle is 8 cycles.
REQ-018 ov SHALL equal (a[31]==b[31]) && (s[31]!=a[31]), using the sign bits captured at E0.
REQ-019 A start asserted while BUSY SHALL be ignored, and operand input changes during BUSY SHALL have no effect.
REQ-020 A start asserted in the done cycle SHALL be accepted (FSM is IDLE), giving a throughput of one result per 9 cycles.
REQ-021 s, co and ov SHALL hold their last values until the next E8 and SHALL NOT change at E0.
REQ-022 The carry SHALL propagate across all nibble boundaries through the carry register, with no wrap-around of the counter beyond NIBBLES-1.

Reset
REQ-023 On reset=1 at a clock edge, the block SHALL set s=0, co=0, ov=0, busy=0, done=0, clear the counter, carry and operand registers, and enter IDLE.
REQ-024 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-025 If reset and start are both 1 at the same edge, reset SHALL win and the start SHALL be dropped.

Verification
REQ-026 Reset held 2 cycles, then released -> s=0, co=0, ov=0, busy=0, done=0.
REQ-027 start with a=0x00000002, b=0x00000004, ci=0 -> done 8 cycles later; s=0x00000006, co=0, ov=0; busy high for exactly 8 cycles.
REQ-028 start with a=0xFFFFFFFF, b=0x00000000, ci=1 -> s=0x00000000, co=1, ov=0 (carry ripples through all 8 nibbles).
REQ-029 Two starts: a=0x7FFFFFFF, b=0x00000001, ci=0 -> s=0x80000000, co=0, ov=1; then, in the done cycle, start with a=0x80000000, b=0x80000000, ci=0 -> s=0x00000000, co=1, ov=1 nine cycles after the first done.
REQ-030 Sequence:
- start with a=0x0000000F, b=0x00000001, ci=0;
- 3 cycles later, start with a=0x12345678, b=0x11111111;
- required: second start ignored, s=0x00000010, co=0.
REQ-031 start, then reset=1 at the 4th BUSY cycle -> busy=0 and s=0 on the next cycle; no done pulse within the next 10 cycles.

Source files
------------

// File: rtl/nibble_serial_add32.sv
// Nibble-serial adder: a + b + ci through one 4-bit carry-lookahead slice,
// one nibble per clock, LSB first; registered sum, carry-out and overflow.

module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p, g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end
endmodule

module nibble_serial_add32 #(
  parameter int NIBBLES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic               ci,
  output logic [4*NIBBLES-1:0] s,
  output logic               co,
  output logic               ov,
  output logic               busy,
  output logic               done
);
  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state, state_nxt;
  logic [W-1:0]              opa, opb;
  logic                      cy, sa, sb;
  logic [CW-1:0]             cnt;
  logic [NIBBLES-1:0][3:0]   res, res_nxt;
  logic [3:0]                nsum;
  logic                      nco;
  logic                      last;

  cla4 u_cla4 (
    .a  (opa[3:0]),
    .b  (opb[3:0]),
    .ci (cy),
    .s  (nsum),
    .co (nco)
  );

  assign last = (cnt == CW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == BUSY);
  end

  // Result as it stands after this edge; on the last nibble it is the full sum.
  always_comb begin
    res_nxt      = res;
    res_nxt[cnt] = nsum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa  <= '0;
      opb  <= '0;
      cy   <= 1'b0;
      sa   <= 1'b0;
      sb   <= 1'b0;
      cnt  <= '0;
      res  <= '0;
      s    <= '0;
      co   <= 1'b0;
      ov   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          opa <= a;
          opb <= b;
          cy  <= ci;
          sa  <= a[W-1];
          sb  <= b[W-1];
          cnt <= '0;
          res <= '0;
        end
      end else begin
        res <= res_nxt;
        cy  <= nco;
        opa <= {4'b0, opa[W-1:4]};
        opb <= {4'b0, opb[W-1:4]};
        if (last) begin
          // Overflow uses the sign bits captured at start, not the shifted operands.
          s    <= res_nxt;
          co   <= nco;
          ov   <= (sa == sb) && (res_nxt[NIBBLES-1][3] != sa);
          done <= 1'b1;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_add32.sv
// Directed bench for nibble_serial_add32 with hand-computed expected results.

module tb_nibble_serial_add32;
  logic        clk = 1'b0;
  logic        reset, start, ci;
  logic [31:0] a, b, s;
  logic        co, ov, busy, done;

  int npass = 0;
  int ntotal = 0;
  logic [31:0] last_s = '0;

  nibble_serial_add32 #(.NIBBLES(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ci(ci),
    .s(s), .co(co), .ov(ov), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Issue one start, optionally inject a second start (with other operands)
  // inj cycles after the start edge, then wait for done with a cycle bound.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic ici,
                        input int inj, output int lat, output int bc);
    a = ia; b = ib; ci = ici; start = 1'b1;
    step();
    start = 1'b0;
    check("s_hold_at_start", s, last_s);
    check("busy_after_start", busy, 1);
    lat = 0;
    bc  = busy ? 1 : 0;
    while (!done && lat < 20) begin
      if (lat == inj) begin
        a = 32'h12345678; b = 32'h11111111; ci = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
        a = ~a; b = b + 32'h1;
      end
      step();
      lat++;
      if (!done && busy) bc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
  endtask

  initial begin
    int lat, bc;
    bit seen;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_s", s, 0);
    check("rst_co", co, 0);
    check("rst_ov", ov, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // 2 + 4
    run_op(32'h00000002, 32'h00000004, 1'b0, -1, lat, bc);
    check("t1_latency", lat, 8);
    check("t1_busy_cycles", bc, 8);
    check("t1_s", s, 32'h00000006);
    check("t1_co", co, 0);
    check("t1_ov", ov, 0);
    last_s = 32'h00000006;
    step();
    check("t1_done_one_cycle", done, 0);
    check("t1_s_hold", s, 32'h00000006);

    // full ripple carry through every nibble
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, -1, lat, bc);
    check("t2_s", s, 32'h00000000);
    check("t2_co", co, 1);
    check("t2_ov", ov, 0);
    last_s = 32'h00000000;
    step();

    // positive overflow, then back-to-back start in the done cycle
    run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, -1, lat, bc);
    check("t3a_s", s, 32'h80000000);
    check("t3a_co", co, 0);
    check("t3a_ov", ov, 1);
    last_s = 32'h80000000;
    run_op(32'h80000000, 32'h80000000, 1'b0, -1, lat, bc);
    check("t3b_latency", lat, 8);
    check("t3b_s", s, 32'h00000000);
    check("t3b_co", co, 1);
    check("t3b_ov", ov, 1);
    last_s = 32'h00000000;
    step();

    // start while busy and operand changes during busy are ignored
    run_op(32'h0000000F, 32'h00000001, 1'b0, 3, lat, bc);
    check("t4_latency", lat, 8);
    check("t4_s", s, 32'h00000010);
    check("t4_co", co, 0);
    check("t4_ov", ov, 0);
    last_s = 32'h00000010;
    step();
    check("t4_no_second_busy", busy, 0);

    // reset at the 4th busy cycle aborts with no done
    a = 32'h00000001; b = 32'h00000001; ci = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_busy_after_rst", busy, 0);
    check("t5_s_after_rst", s, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done || busy) seen = 1'b1;
    end
    check("t5_no_done", seen, 0);
    last_s = 32'h00000000;

    // reset beats a simultaneous start
    a = 32'h00000003; b = 32'h00000003; reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    check("t6_rst_wins_busy", busy, 0);
    step();
    check("t6_still_idle", busy, 0);

    // signed -1 + -1 + 1: both negative, result negative, no overflow
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, -1, lat, bc);
    check("t7_s", s, 32'hFFFFFFFF);
    check("t7_co", co, 1);
    check("t7_ov", ov, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
